// File: rtl/icache_pkg.sv
// ----------------------------------------------------------------------------
// icache_pkg
// Shared constants and types for the direct-mapped instruction cache.
//   Address split (byte address): tag = [15:10], index = [9:4], offset = [3:1].
//   MEM_LAT_DEF is the fixed main-memory read latency. The fill controller does
//   not depend on it, because it counts returns instead of timing them.
// ----------------------------------------------------------------------------
package icache_pkg;

   localparam int TAG_W = 6;
   localparam int IDX_W = 6;
   localparam int OFF_W = 3;

   localparam int OFF_LSB = 1;
   localparam int IDX_LSB = OFF_LSB + OFF_W;
   localparam int TAG_LSB = IDX_LSB + IDX_W;

   localparam int MEM_LAT_DEF       = 4;
   localparam int WORDS_PER_BLK_DEF = 8;
   localparam int NUM_BLKS_DEF      = 64;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_e;

endpackage

// File: rtl/icache_array.sv
// ----------------------------------------------------------------------------
// icache_array
// Valid/tag/data storage for the direct-mapped instruction cache.
//   clk, rst        : clock, async active-high reset (clears valid bits only)
//   rd_idx_i/off_i  : combinational read port -> rd_valid_o, rd_tag_o, rd_data_o
//   dwe_i, dw_*     : data word write port (index, offset, data)
//   twe_i, tw_*     : tag/valid write port (index, tag, valid value)
//   inval_i         : clears every valid bit at the next edge
// Tag and data storage have no reset.
// ----------------------------------------------------------------------------
module icache_array
   import icache_pkg::*;
#(
   parameter int NUM_BLKS      = NUM_BLKS_DEF,
   parameter int WORDS_PER_BLK = WORDS_PER_BLK_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx_i,
   input  logic [OFF_W-1:0] rd_off_i,
   output logic             rd_valid_o,
   output logic [TAG_W-1:0] rd_tag_o,
   output logic [15:0]      rd_data_o,
   input  logic             dwe_i,
   input  logic [IDX_W-1:0] dw_idx_i,
   input  logic [OFF_W-1:0] dw_off_i,
   input  logic [15:0]      dw_data_i,
   input  logic             twe_i,
   input  logic [IDX_W-1:0] tw_idx_i,
   input  logic [TAG_W-1:0] tw_tag_i,
   input  logic             tw_valid_i,
   input  logic             inval_i
);

   logic [NUM_BLKS-1:0] valid_q;
   logic [TAG_W-1:0]    tag_q  [NUM_BLKS];
   logic [15:0]         data_q [NUM_BLKS][WORDS_PER_BLK];

   // Invalidate beats a same-edge tag write, so a line finishing its fill
   // while a flush lands is left invalid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
      end else if (inval_i) begin
         valid_q <= '0;
      end else if (twe_i) begin
         valid_q[tw_idx_i] <= tw_valid_i;
      end
   end

   always_ff @(posedge clk) begin
      if (twe_i) tag_q[tw_idx_i] <= tw_tag_i;
      if (dwe_i) data_q[dw_idx_i][dw_off_i] <= dw_data_i;
   end

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_data_o  = data_q[rd_idx_i][rd_off_i];

endmodule

// File: rtl/icache_fill_ctrl.sv
// ----------------------------------------------------------------------------
// icache_fill_ctrl
// Direct-mapped instruction cache with a miss/fill controller.
//   clk, rst            : clock, async active-high reset
//   fetch_req/addr      : fetch lookup (combinational hit path)
//   flush               : one-cycle pulse, invalidates all lines
//   instr, instr_valid  : hit data / hit strobe
//   stall               : miss in progress, fetch holds its PC
//   mem_rd, mem_addr    : pipelined read requests, one word per cycle
//   mem_data, mem_valid : in-order read returns
//   hit_cnt, miss_cnt   : statistics counters
// Optional feature macro: ICACHE_STATS_EN (when undefined, the counters are tied to 0).
// ----------------------------------------------------------------------------
module icache_fill_ctrl
   import icache_pkg::*;
#(
   parameter int WORDS_PER_BLK = WORDS_PER_BLK_DEF,
   parameter int NUM_BLKS      = NUM_BLKS_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_req,
   input  logic [15:0] fetch_addr,
   input  logic        flush,
   output logic [15:0] instr,
   output logic        instr_valid,
   output logic        stall,
   output logic        mem_rd,
   output logic [15:0] mem_addr,
   input  logic [15:0] mem_data,
   input  logic        mem_valid,
   output logic [15:0] hit_cnt,
   output logic [15:0] miss_cnt
);

   localparam int BASE_W = TAG_W + IDX_W;
   localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_BLK - 1);

   state_e              state_q, state_d;
   logic [BASE_W-1:0]   base_q, base_d;         // latched block address bits [15:4]
   logic [OFF_W-1:0]    k_q, k_d;               // issue counter
   logic [OFF_W-1:0]    r_q, r_d;               // receive counter
   logic                issue_done_q, issue_done_d;
   logic                flush_pend_q, flush_pend_d;

   logic                rd_valid;
   logic [TAG_W-1:0]    rd_tag;
   logic [15:0]         rd_data;
   logic                dwe, twe, tw_valid;
   logic                miss_start;
   logic                addr_unused;

   assign addr_unused = fetch_addr[0];

   icache_array #(
      .NUM_BLKS      (NUM_BLKS),
      .WORDS_PER_BLK (WORDS_PER_BLK)
   ) u_array (
      .clk        (clk),
      .rst        (rst),
      .rd_idx_i   (fetch_addr[IDX_LSB +: IDX_W]),
      .rd_off_i   (fetch_addr[OFF_LSB +: OFF_W]),
      .rd_valid_o (rd_valid),
      .rd_tag_o   (rd_tag),
      .rd_data_o  (rd_data),
      .dwe_i      (dwe),
      .dw_idx_i   (base_q[IDX_W-1:0]),
      .dw_off_i   (r_q),
      .dw_data_i  (mem_data),
      .twe_i      (twe),
      .tw_idx_i   (base_q[IDX_W-1:0]),
      .tw_tag_i   (base_q[BASE_W-1:IDX_W]),
      .tw_valid_i (tw_valid),
      .inval_i    (flush)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         base_q       <= '0;
         k_q          <= '0;
         r_q          <= '0;
         issue_done_q <= 1'b0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         base_q       <= base_d;
         k_q          <= k_d;
         r_q          <= r_d;
         issue_done_q <= issue_done_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      base_d       = base_q;
      k_d          = k_q;
      r_d          = r_q;
      issue_done_d = issue_done_q;
      flush_pend_d = flush_pend_q;
      instr        = 16'h0000;
      instr_valid  = 1'b0;
      stall        = 1'b0;
      mem_rd       = 1'b0;
      mem_addr     = 16'h0000;
      dwe          = 1'b0;
      twe          = 1'b0;
      tw_valid     = 1'b0;
      miss_start   = 1'b0;

      case (state_q)
         IDLE: begin
            flush_pend_d = 1'b0;
            // Gated by rst so the outputs stay quiet while reset is held,
            // even if fetch keeps requesting.
            if (fetch_req && !rst) begin
               if (rd_valid && (rd_tag == fetch_addr[TAG_LSB +: TAG_W])) begin
                  instr_valid = 1'b1;
                  instr       = rd_data;
               end else begin
                  stall        = 1'b1;
                  miss_start   = 1'b1;
                  base_d       = fetch_addr[15:IDX_LSB];
                  k_d          = '0;
                  r_d          = '0;
                  issue_done_d = 1'b0;
                  state_d      = FILL;
               end
            end
         end

         FILL: begin
            stall = 1'b1;
            if (flush) flush_pend_d = 1'b1;

            if (!issue_done_q) begin
               mem_rd   = 1'b1;
               mem_addr = {base_q, k_q, 1'b0};
               // Hold k at the last word and use the done flag instead of wrapping.
               if (k_q == LAST_WORD) issue_done_d = 1'b1;
               else                  k_d = k_q + 1'b1;
            end

            if (mem_valid) begin
               dwe = 1'b1;
               if (r_q == LAST_WORD) begin
                  twe          = 1'b1;
                  // A flush on this very cycle counts as pending too.
                  tw_valid     = !(flush_pend_q || flush);
                  flush_pend_d = 1'b0;
                  state_d      = IDLE;
               end else begin
                  r_d = r_q + 1'b1;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

`ifdef ICACHE_STATS_EN
   logic [15:0] hit_cnt_q, miss_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_cnt_q  <= 16'h0000;
         miss_cnt_q <= 16'h0000;
      end else begin
         if (instr_valid && (hit_cnt_q != 16'hFFFF)) hit_cnt_q <= hit_cnt_q + 16'h0001;
         if (miss_start && (miss_cnt_q != 16'hFFFF)) miss_cnt_q <= miss_cnt_q + 16'h0001;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`else
   logic stats_unused;
   assign stats_unused = miss_start;
   assign hit_cnt  = 16'h0000;
   assign miss_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// ----------------------------------------------------------------------------
// tb_icache_fill_ctrl
// Directed bench for icache_fill_ctrl with a 4-cycle pipelined memory model.
// Memory word at address a returns {a[7:0], ~a[15:8]} ^ 16'h5A3C.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// ----------------------------------------------------------------------------
module tb_icache_fill_ctrl;

   localparam int MEM_LAT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_req;
   logic [15:0] fetch_addr;
   logic        flush;
   logic [15:0] instr;
   logic        instr_valid;
   logic        stall;
   logic        mem_rd;
   logic [15:0] mem_addr;
   logic [15:0] mem_data;
   logic        mem_valid;
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   icache_fill_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .flush       (flush),
      .instr       (instr),
      .instr_valid (instr_valid),
      .stall       (stall),
      .mem_rd      (mem_rd),
      .mem_addr    (mem_addr),
      .mem_data    (mem_data),
      .mem_valid   (mem_valid),
      .hit_cnt     (hit_cnt),
      .miss_cnt    (miss_cnt)
   );

   function automatic logic [15:0] memf(input logic [15:0] a);
      return {a[7:0], ~a[15:8]} ^ 16'h5A3C;
   endfunction

   // Fixed-latency memory; keeps running through reset so stale returns appear.
   logic [MEM_LAT:1]       pv;
   logic [MEM_LAT:1][15:0] pa;
   always @(posedge clk) begin
      pv[1] <= mem_rd;
      pa[1] <= mem_addr;
      for (int i = 2; i <= MEM_LAT; i++) begin
         pv[i] <= pv[i-1];
         pa[i] <= pa[i-1];
      end
   end
   assign mem_valid = pv[MEM_LAT];
   assign mem_data  = pv[MEM_LAT] ? memf(pa[MEM_LAT]) : 16'h0000;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   // Caller is at a falling edge; waits for stall to drop (bounded).
   task automatic wait_fill(input string tag);
      int n = 0;
      while (stall && n < 40) begin
         mid();
         n++;
      end
      chk({tag, "_fill_done"}, stall, 1'b0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      fetch_req  = 1'b0;
      fetch_addr = 16'h0000;
      flush      = 1'b0;
      repeat (6) cyc();
      mid();
      chk("rst_stall", stall, 1'b0);
      chk("rst_iv",    instr_valid, 1'b0);
      chk("rst_instr", instr, 16'h0000);
      chk("rst_mem_rd", mem_rd, 1'b0);
      chk("rst_mem_addr", mem_addr, 16'h0000);
      chk("rst_hit_cnt", hit_cnt, 16'h0000);
      chk("rst_miss_cnt", miss_cnt, 16'h0000);
      cyc();
      rst = 1'b0;
      cyc();

      // Cold miss at 0x0010: cycle 0 miss, requests 1..8, stall through 12.
      fetch_req  = 1'b1;
      fetch_addr = 16'h0010;
      mid();
      chk("c0_stall", stall, 1'b1);
      chk("c0_iv", instr_valid, 1'b0);
      chk("c0_mem_rd", mem_rd, 1'b0);
      for (int c = 1; c <= 12; c++) begin
         cyc();
         mid();
         chk($sformatf("c%0d_stall", c), stall, 1'b1);
         if (c <= 8) begin
            chk($sformatf("c%0d_mem_rd", c), mem_rd, 1'b1);
            chk($sformatf("c%0d_mem_addr", c), mem_addr, 16'h0010 + 16'(2 * (c - 1)));
         end else begin
            chk($sformatf("c%0d_mem_rd", c), mem_rd, 1'b0);
         end
      end
      cyc();
      mid();
      chk("c13_stall", stall, 1'b0);
      chk("c13_iv", instr_valid, 1'b1);
      chk("c13_instr", instr, 16'h4AC3);

      // Rest of the block hits back to back.
      for (int i = 1; i < 8; i++) begin
         cyc();
         fetch_addr = 16'h0010 + 16'(2 * i);
         mid();
         chk($sformatf("hit%0d_iv", i), instr_valid, 1'b1);
         chk($sformatf("hit%0d_instr", i), instr, memf(fetch_addr));
         chk($sformatf("hit%0d_stall", i), stall, 1'b0);
         chk($sformatf("hit%0d_mem_rd", i), mem_rd, 1'b0);
      end

      // Conflict on index 0: tag 0 vs tag 1.
      cyc();
      fetch_addr = 16'h0000;
      mid();
      chk("cf0_miss", stall, 1'b1);
      wait_fill("cf0");
      chk("cf0_instr", instr, memf(16'h0000));
      cyc();
      fetch_addr = 16'h0400;
      mid();
      chk("cf1_miss", stall, 1'b1);
      wait_fill("cf1");
      chk("cf1_iv", instr_valid, 1'b1);
      chk("cf1_instr", instr, memf(16'h0400));
      cyc();
      fetch_addr = 16'h0000;
      mid();
      chk("cf2_miss", stall, 1'b1);
      wait_fill("cf2");
      chk("cf2_instr", instr, memf(16'h0000));

      // Flush at fill cycle 5: fill completes but leaves the line invalid.
      cyc();
      fetch_addr = 16'h0020;
      for (int c = 1; c <= 5; c++) cyc();
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      for (int c = 7; c <= 12; c++) cyc();
      mid();
      chk("fl_c12_stall", stall, 1'b1);
      cyc();
      fetch_req = 1'b0;
      mid();
      chk("fl_c13_stall", stall, 1'b0);
      chk("fl_c13_mem_rd", mem_rd, 1'b0);
      cyc();
      fetch_req = 1'b1;
      mid();
      chk("fl_remiss", stall, 1'b1);
      wait_fill("fl");
      chk("fl_instr", instr, memf(16'h0020));

      // Flush coinciding with a hit still returns the hit.
      cyc();
      flush = 1'b1;
      mid();
      chk("fh_iv", instr_valid, 1'b1);
      chk("fh_instr", instr, memf(16'h0020));
      cyc();
      flush = 1'b0;
      mid();
      chk("fh_remiss", stall, 1'b1);
      wait_fill("fh");
      cyc();
      fetch_addr = 16'h0018;
      mid();
      chk("fh_other_inval", stall, 1'b1);
      wait_fill("fh2");
      chk("fh2_instr", instr, memf(16'h0018));

      // Reset at fill cycle 6; late returns must be ignored.
      cyc();
      fetch_addr = 16'h0030;
      for (int c = 1; c <= 6; c++) cyc();
      rst = 1'b1;
      #1;
      chk("rs_stall", stall, 1'b0);
      chk("rs_mem_rd", mem_rd, 1'b0);
      chk("rs_iv", instr_valid, 1'b0);
      cyc();
      cyc();
      rst       = 1'b0;
      fetch_req = 1'b0;
      repeat (8) cyc();
      fetch_req = 1'b1;
      mid();
      chk("rs_miss", stall, 1'b1);
      chk("rs_miss_cnt0", miss_cnt, 16'h0000);
      wait_fill("rs");
      chk("rs_instr", instr, memf(16'h0030));
      for (int i = 1; i < 8; i++) begin
         cyc();
         fetch_addr = 16'h0030 + 16'(2 * i);
         mid();
         chk($sformatf("rs_hit%0d", i), instr, memf(fetch_addr));
      end
      cyc();
      fetch_req = 1'b0;
      mid();
`ifdef ICACHE_STATS_EN
      chk("st_miss_cnt", miss_cnt, 16'h0001);
      chk("st_hit_cnt", hit_cnt, 16'h0008);
      // Saturation: keep hitting well past 0xFFFF.
      cyc();
      fetch_req  = 1'b1;
      fetch_addr = 16'h0030;
      repeat (65600) cyc();
      mid();
      chk("st_hit_sat", hit_cnt, 16'hFFFF);
      cyc();
      cyc();
      mid();
      chk("st_hit_hold", hit_cnt, 16'hFFFF);
      chk("st_miss_hold", miss_cnt, 16'h0001);
      fetch_req = 1'b0;
`else
      chk("st_hit_tied", hit_cnt, 16'h0000);
      chk("st_miss_tied", miss_cnt, 16'h0000);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/icache_fill_ctrl.md
Name: icache_fill_ctrl

Overview:
- Direct-mapped instruction cache with miss/fill controller, directly upstream of the fetch stage.
- Serves 16-bit instruction words to fetch; raises stall on a miss.
- Fills 8-word blocks from a pipelined main memory with fixed latency.
- Fetch holds the PC and re-presents the same address while stall=1.

Parameters:
- MEM_LAT, 4: cycles from mem_rd to the matching mem_valid/mem_data.
- WORDS_PER_BLK, 8: 16-bit words per block.
- NUM_BLKS, 64: cache lines, giving 1 KB of data.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- fetch_req  in  1  fetch wants an instruction this cycle
- fetch_addr  in  16  byte address; bit 0 ignored
- flush  in  1  one-cycle pulse; invalidate all lines
- instr  out  16  instruction word; valid when instr_valid=1
- instr_valid  out  1  hit this cycle
- stall  out  1  miss in progress; fetch must hold its PC
- mem_rd  out  1  read request to main memory
- mem_addr  out  16  word-aligned request address
- mem_data  in  16  read return data
- mem_valid  in  1  mem_data valid; returns arrive in request order
- hit_cnt  out  16  hit count (optional feature)
- miss_cnt  out  16  miss count (optional feature)

Behaviour:
- Address split: tag=addr[15:10], index=addr[9:4], offset=addr[3:1].
- Reset (async): state=IDLE, all valid bits 0, counters 0, mem_rd=0, mem_addr=0, stall=0, instr_valid=0, instr=0. Tag/data arrays are not reset.
- Lookup is combinational. In IDLE, fetch_req=1 and valid[index] and tag match -> instr_valid=1, instr=data[index][offset], stall=0, same cycle.
- fetch_req=0 -> instr_valid=0, stall=0, no miss started.
- Miss in IDLE (fetch_req=1, no hit):
  - stall=1, instr_valid=0.
  - Latch block base {addr[15:4],4'b0}; next state FILL.
- FILL:
  - stall=1 throughout.
  - Issue counter k=0..7: mem_rd=1, mem_addr=base+2k on 8 consecutive cycles, then mem_rd=0.
  - Receive counter r increments on each mem_valid; data[idx][r]=mem_data.
  - On the 8th mem_valid: write tag and set valid (unless flush_pending) at that edge; go to IDLE.
- Cold-miss timing: miss seen at cycle 0; requests at cycles 1..8; returns at cycles 1+MEM_LAT..8+MEM_LAT; stall=1 for cycles 0..12; hit at cycle 13.
- fetch_addr may change during FILL (redirect):
  - The fill completes for the latched block.
  - Lookup resumes in IDLE with the current address; this may miss again immediately.
- flush:
  - Clears all valid bits at the next edge, in any state.
  - If it arrives during FILL, set flush_pending; the finishing fill writes data/tag but leaves valid=0; flush_pending clears on return to IDLE.
  - A flush coinciding with a hit cycle still returns that hit.
- mem_valid in IDLE is ignored, covering stale returns after a mid-fill reset.
- Reset mid-fill: immediate IDLE, mem_rd=0, valid bits cleared.
- Counters: k and r are 3-bit and must not wrap past 7. An issue-done flag stops requests.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - hit_cnt increments on each cycle with instr_valid=1.
  - miss_cnt increments on each IDLE->FILL transition.
  - Both are 16-bit, saturate at 0xFFFF, clear on rst, and are unaffected by flush.
- Undefined: counter logic is absent; hit_cnt and miss_cnt are tied to 0 so the interface is unchanged.

Decomposition:
- icache_pkg holds:
  - field widths TAG_W=6, IDX_W=6, OFF_W=3;
  - state enum {IDLE, FILL};
  - default MEM_LAT and WORDS_PER_BLK.
- Sub-module icache_array holds the valid/tag/data storage:
  - one combinational read port (index, offset);
  - one data write port (index, offset);
  - one tag/valid write port;
  - a global invalidate input.

Test Plan:
- Cold miss at 0x0010 -> mem_addr 0x0010..0x001E on cycles 1..8; stall cycles 0..12; cycle 13 instr=mem word@0x0010, instr_valid=1.
- After that fill, fetch 0x0012, 0x0014, ... 0x001E back-to-back -> 8 consecutive hits, no mem_rd, stall=0.
- Conflict: fill 0x0000, then access 0x0400 (same index, tag 1) -> miss; then 0x0000 -> miss again.
- flush at fill cycle 5 -> fill completes, stall drops at cycle 13; same address then misses again (valid=0).
- rst asserted at fill cycle 6 -> immediate stall=0, mem_rd=0; late mem_valid pulses cause no array write; next fetch misses.
- ICACHE_STATS_EN defined: 1 miss plus 8 hits -> miss_cnt=1, hit_cnt=8. Preload hit_cnt near 0xFFFF with hits -> it holds at 0xFFFF.
